// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: FSM state encoding and board timing constants shared by the debouncer slice.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_t;

    localparam int CLK_HZ      = 100_000_000;
    localparam int DEBOUNCE_MS = 5;

    function automatic int stable_count_for(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    localparam int DEFAULT_STABLE_COUNT = stable_count_for(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop synchronizer for an asynchronous level input, async active-low reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_chain <= '0;
        else          r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a bouncing button and accepts a new level only after
// STABLE_COUNT consecutive identical synchronized samples.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic CLOCK,
    input  logic Reset,
    input  logic ButtonIn,
    output logic ButtonClean,
    output logic Busy
);

    localparam int                   CNT_WIDTH = $clog2(STABLE_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 w_sync;
    deb_state_t           r_state;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_clean;
    logic                 r_busy;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk  (CLOCK),
        .i_rst_n(Reset),
        .i_d    (ButtonIn),
        .o_q    (w_sync)
    );

    // Outputs are registered alongside the state so they never glitch.
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE_LOW;
            r_count <= '0;
            r_clean <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE_LOW: begin
                    if (w_sync) begin
                        r_state <= WAIT_HIGH;
                        r_count <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_count <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!w_sync) begin
                        r_state <= IDLE_LOW;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_count == CNT_LAST) begin
                        r_state <= IDLE_HIGH;
                        r_count <= '0;
                        r_clean <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!w_sync) begin
                        r_state <= WAIT_LOW;
                        r_count <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_count <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (w_sync) begin
                        r_state <= IDLE_HIGH;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_count == CNT_LAST) begin
                        r_state <= IDLE_LOW;
                        r_count <= '0;
                        r_clean <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE_LOW;
                    r_count <= '0;
                    r_clean <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ButtonClean = r_clean;
    assign Busy        = r_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench; a run-length reference model predicts ButtonClean/Busy every cycle.
module tb_button_debouncer;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn   = 1'b1;
    logic clean;
    logic busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    logic       pipe[$];
    int         run     = 0;
    logic       m_clean = 1'b0;

    logic os_prev, os;
    int   os_hi = 0;

    button_debouncer #(.STABLE_COUNT(STABLE), .SYNC_STAGES(SYNC)) dut (
        .CLOCK      (clk),
        .Reset      (rst_n),
        .ButtonIn   (btn),
        .ButtonClean(clean),
        .Busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", nm, got, want, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    // Reference: the synchronizer is a pure SYNC-sample delay; the clean level flips once
    // STABLE consecutive delayed samples disagree with it, and Busy means a disagreement run is open.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            pipe.delete();
            run     = 0;
            m_clean = 1'b0;
        end else begin
            logic s;
            while (pipe.size() < SYNC) pipe.push_back(1'b0);
            s = pipe.pop_front();
            pipe.push_back(btn);
            if (s != m_clean) begin
                run++;
                if (run == STABLE) begin
                    m_clean = ~m_clean;
                    run     = 0;
                end
            end else begin
                run = 0;
            end
            exp_q.push_back({m_clean, run != 0});
        end
    end

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            check_bit("sb_clean", clean, e[1]);
            check_bit("sb_busy", busy, e[0]);
        end
    end

    // Downstream rising-edge one-shot fed by ButtonClean.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_prev <= 1'b0;
            os      <= 1'b0;
        end else begin
            os      <= clean & ~os_prev;
            os_prev <= clean;
        end
    end

    always @(negedge clk) if (os === 1'b1) os_hi++;

    task automatic edges_until(input logic lvl, input int want, input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (clean !== lvl && n < 40);
        check_int(nm, n, want);
    endtask

    task automatic hold(input logic v, input int n, output int hi);
        hi  = 0;
        btn = v;
        repeat (n) begin
            @(posedge clk);
            #3;
            hi += int'(clean);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, tot, os_start;
        #1;
        check_bit("rst_clean", clean, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        #12 rst_n = 1'b1;
        edges_until(1'b1, 6, "release_latency");

        repeat (10) @(negedge clk);
        #2 btn = 1'b0;
        edges_until(1'b0, 6, "release_fall");
        #2 btn = 1'b1;
        edges_until(1'b1, 6, "press_rise");
        repeat (10) @(negedge clk);
        #2 btn = 1'b0;
        edges_until(1'b0, 6, "press_fall");

        hold(1'b0, 8, hi);
        tot = 0;
        hold(1'b1, 3, hi); tot += hi;
        hold(1'b0, 1, hi); tot += hi;
        hold(1'b1, 2, hi); tot += hi;
        hold(1'b0, 12, hi); tot += hi;
        check_int("bounce_clean_hi", tot, 0);
        check_bit("bounce_busy_end", busy, 1'b0);

        tot = 0;
        hold(1'b1, 4, hi); tot += hi;
        hold(1'b0, 15, hi); tot += hi;
        check_bit("thresh4_accept", tot >= 4, 1'b1);
        tot = 0;
        hold(1'b1, 3, hi); tot += hi;
        hold(1'b0, 15, hi); tot += hi;
        check_int("thresh3_reject", tot, 0);

        btn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_bit("midwait_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_bit("midwait_rst_clean", clean, 1'b0);
        check_bit("midwait_rst_busy", busy, 1'b0);
        #4 rst_n = 1'b1;
        edges_until(1'b1, 6, "requal_latency");

        #3 rst_n = 1'b0;
        #1 check_bit("idlehigh_rst_clean", clean, 1'b0);
        #2 rst_n = 1'b1;
        btn = 1'b0;
        repeat (8) @(posedge clk);
        #3;

        repeat (300) hold(1'($urandom_range(0, 1)), $urandom_range(1, 8), hi);

        hold(1'b0, 12, hi);
        os_start = os_hi;
        for (int i = 0; i < 5; i++) begin
            btn = ~btn;
            #($urandom_range(1, 3) * 10);
        end
        hold(1'b1, 20, hi);
        check_int("oneshot_pulses", os_hi - os_start, 1);
        check_bit("oneshot_clean_held", clean, 1'b1);

        repeat (3) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
